ifetch_prefetch_buffer: RTL and testbench

//  Instruction-fetch front end for the five-stage MIPS cpu. Takes cpu pc, returns the instruction word
//  and the pc-advance enable. Prefetches sequential words from a variable-latency instruction memory

---
 rtl/ifetch_prefetch_buffer_if.sv | 19 +
 rtl/ifetch_prefetch_buffer.sv | 61 ++++++
 tb/tb_ifetch_prefetch_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_buffer_if.sv
// ifetch_prefetch_buffer_if: cpu fetch port plus instruction-memory request/response bus
interface ifetch_prefetch_buffer_if;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_inst;
    logic        cpu_pc_en;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    modport master (
        input  cpu_pc, mem_gnt, mem_rvalid, mem_rdata,
        output cpu_inst, cpu_pc_en, mem_req, mem_addr
    );
    modport slave (
        output cpu_pc, mem_gnt, mem_rvalid, mem_rdata,
        input  cpu_inst, cpu_pc_en, mem_req, mem_addr
    );
endinterface

// File: rtl/ifetch_prefetch_buffer.sv
// ifetch_prefetch_buffer: in-order sequential prefetch queue with redirect and stale-response discard
module ifetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                      clk,
    input logic                      reset,
    ifetch_prefetch_buffer_if.master bus
);
    // one spare bit so count+outst and drop+outst never wrap before saturation
    localparam int CW = $clog2(DEPTH + 1) + 1;
    logic [31:0]   head_q, head_d, fetch_q, fetch_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [31:0]   ent_q [DEPTH];
    logic [31:0]   ent_d [DEPTH];
    logic          hit0, adv, hit1, redirect, gnt, push;
    logic [CW-1:0] slot, drop_sum;

    always_comb begin
        hit0 = count_q != '0 && bus.cpu_pc == head_q;
        adv = count_q != '0 && bus.cpu_pc == head_q + 32'd4;
        hit1 = adv && count_q >= CW'(2);
        redirect = !hit0 && !adv && !(count_q == '0 && bus.cpu_pc == head_q);
        bus.cpu_pc_en = !reset && (hit0 || hit1);
        bus.cpu_inst = reset ? '0 : hit0 ? ent_q[0] : hit1 ? ent_q[1] : '0;
        bus.mem_req = !reset && !redirect && count_q + outst_q < CW'(DEPTH);
        bus.mem_addr = fetch_q;
        gnt = bus.mem_req && bus.mem_gnt;
        push = bus.mem_rvalid && drop_q == '0 && !redirect;
        slot = count_q - CW'(adv);
        drop_sum = drop_q + outst_q - CW'(bus.mem_rvalid);
        head_d = redirect ? bus.cpu_pc : adv ? head_q + 32'd4 : head_q;
        fetch_d = redirect ? bus.cpu_pc : gnt ? fetch_q + 32'd4 : fetch_q;
        count_d = redirect ? '0 : slot + CW'(push);
        outst_d = outst_q + CW'(gnt) - CW'(bus.mem_rvalid);
        drop_d = redirect ? (drop_sum > CW'(DEPTH) ? CW'(DEPTH) : drop_sum)
                          : drop_q - CW'(bus.mem_rvalid && drop_q != '0);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = (adv && i < DEPTH - 1) ? ent_q[(i + 1) % DEPTH] : ent_q[i];
            if (push && slot == CW'(i)) ent_d[i] = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= RESET_PC;
            fetch_q <= RESET_PC;
            count_q <= '0;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            head_q  <= head_d;
            fetch_q <= fetch_d;
            count_q <= count_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) ent_q <= ent_d;
endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// tb_ifetch_prefetch_buffer: cpu/memory models with an instruction scoreboard and a redirect vector table
module tb_ifetch_prefetch_buffer;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    ifetch_prefetch_buffer_if bus();
    ifetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { logic [31:0] a; int due; } resp_t;
    typedef struct { int lat; int pre; logic [31:0] tgt; int exp_hit; int exp_gnts; bit steady; } vec_t;

    resp_t       pend[$];
    logic [31:0] exp_q[$];
    vec_t        tv[6];
    int          checks = 0, failures = 0, cyc = 0, lat = 1, gnt_block = 0, miss = 0, gnts = 0;
    logic        next_rst = 1, adv = 1, p_req = 0, p_gnt = 0;
    logic [31:0] next_pc = 0, p_addr = 0, en_s = 0, req_s = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // memory word at byte address a is a>>2; the cpu's expected word is queued when it drives a pc
    task automatic set_pc(input logic [31:0] a);
        next_pc = a;
        exp_q.delete();
        exp_q.push_back(a >> 2);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        reset = next_rst;
        bus.cpu_pc = next_pc;
        bus.mem_rvalid = 0;
        bus.mem_rdata = 0;
        if (reset) pend.delete();
        else if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.mem_rvalid = 1;
            bus.mem_rdata = pend[0].a >> 2;
            pend.delete(0);
        end
        bus.mem_gnt = gnt_block == 0;
        if (gnt_block > 0) gnt_block--;
        @(negedge clk);
        en_s = 32'(bus.cpu_pc_en);
        req_s = 32'(bus.mem_req);
        if (!reset) begin
            if (en_s != 0) chk("inst", bus.cpu_inst, exp_q.size() != 0 ? exp_q[0] : 32'hDEAD_BEEF);
            else begin
                chk("nop", bus.cpu_inst, 0);
                miss++;
            end
            if (p_req && !p_gnt && req_s != 0) chk("addr_hold", bus.mem_addr, p_addr);
            if (req_s != 0 && bus.mem_gnt) begin
                pend.push_back('{bus.mem_addr, cyc + lat});
                gnts++;
            end
            if (en_s != 0 && adv) set_pc(bus.cpu_pc + 32'd4);
        end
        p_req = req_s != 0 && !reset;
        p_gnt = bus.mem_gnt;
        p_addr = bus.mem_addr;
    endtask

    task automatic do_reset();
        next_rst = 1;
        cycle();
        chk("rst_req", req_s, 0);
        chk("rst_en", en_s, 0);
        next_rst = 0;
        gnts = 0;
        set_pc(32'h0);
    endtask

    task automatic wait_hit(input int base, input int want, input string nm);
        int g = 0;
        do begin
            cycle();
            g++;
        end while (en_s == 0 && g < 40);
        chk(nm, cyc - base, want);
    endtask

    initial begin
        int base;
        bus.cpu_pc = 0;
        bus.mem_gnt = 1;
        bus.mem_rvalid = 0;
        bus.mem_rdata = 0;
        tv[0] = '{1, 3, 32'h0000_0400, 3, 3, 1};
        tv[1] = '{4, 3, 32'h0000_0040, 6, 3, 0};
        tv[2] = '{2, 2, 32'h0000_0040, 4, 2, 0};
        tv[3] = '{2, 5, 32'h0000_0100, 4, 4, 0};
        tv[4] = '{3, 1, 32'hFFFF_FFF8, 5, 1, 0};
        tv[5] = '{1, 0, 32'h0000_0020, 3, 0, 1};

        lat = 1;
        do_reset();
        base = cyc + 1;
        wait_hit(base, 2, "first_hit");
        miss = 0;
        for (int k = 0; k < 20 && next_pc != 32'h10; k++) cycle();
        chk("stream_pc", next_pc, 32'h10);
        adv = 0;
        repeat (4) begin
            cycle();
            chk("hold_en", en_s, 1);
        end
        chk("stream_miss", miss, 0);
        chk("full_req", req_s, 0);

        do_reset();
        repeat (4) cycle();
        do_reset();
        cycle();
        chk("rr_en", en_s, 0);
        chk("rr_req", req_s, 1);
        chk("rr_addr", bus.mem_addr, 0);
        base = cyc;
        wait_hit(base, 2, "rr_hit");

        adv = 1;
        do_reset();
        gnt_block = 5;
        base = cyc + 1;
        repeat (5) begin
            cycle();
            chk("stall_req", req_s, 1);
            chk("stall_addr", bus.mem_addr, 0);
            chk("stall_en", en_s, 0);
        end
        wait_hit(base, 7, "stall_hit");

        for (int i = 0; i < 6; i++) begin
            lat = tv[i].lat;
            do_reset();
            adv = 0;
            repeat (tv[i].pre) cycle();
            chk($sformatf("pre_gnts[%0d]", i), gnts, tv[i].exp_gnts);
            adv = 1;
            base = cyc + 1;
            set_pc(tv[i].tgt);
            wait_hit(base, tv[i].exp_hit, $sformatf("redirect_hit[%0d]", i));
            miss = 0;
            repeat (12) cycle();
            if (tv[i].steady) chk($sformatf("steady_miss[%0d]", i), miss, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
